// File: rtl/addend_stream_packer.sv
// Packs a valid/ready addend stream into the adder chain's wide vector and returns the chain's sum over valid/ready.
// Optional early-end support is enabled with `define ADDEND_STREAM_PACKER_LAST_EN (addend_last_in ignored otherwise).
module addend_stream_packer #(
    parameter int ADDEND_WIDTH      = 16,
    parameter int NUMBER_OF_ADDENDS = 64,
    parameter int FINAL_SUM_WIDTH   = ADDEND_WIDTH,
    parameter int ADDER_LATENCY     = 6
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic [ADDEND_WIDTH-1:0]                         addend_in,
    input  logic                                            addend_valid_in,
    input  logic                                            addend_last_in,
    output logic                                            addend_ready_out,
    output logic [NUMBER_OF_ADDENDS-1:0][ADDEND_WIDTH-1:0]  addends_out,
    input  logic [FINAL_SUM_WIDTH-1:0]                      sum_in,
    output logic [FINAL_SUM_WIDTH-1:0]                      sum_out,
    output logic                                            sum_valid_out,
    input  logic                                            sum_ready_in,
    output logic                                            busy_out
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready never depends on valid, and valid/data hold until the transfer.

    localparam int CNT_W  = $clog2(NUMBER_OF_ADDENDS);
    localparam int WAIT_W = (ADDER_LATENCY > 0) ? $clog2(ADDER_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic              beat_accept;
    logic              end_of_txn;

    assign addend_ready_out = (state == FILL);
    assign busy_out         = (state != FILL);
    assign beat_accept      = addend_valid_in && addend_ready_out;

`ifdef ADDEND_STREAM_PACKER_LAST_EN
    assign end_of_txn = beat_accept &&
                        ((count == CNT_W'(NUMBER_OF_ADDENDS - 1)) || addend_last_in);
`else
    logic unused_last;
    assign unused_last = addend_last_in;
    assign end_of_txn  = beat_accept && (count == CNT_W'(NUMBER_OF_ADDENDS - 1));
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= FILL;
            count         <= '0;
            wait_cnt      <= '0;
            addends_out   <= '0;
            sum_out       <= '0;
            sum_valid_out <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (beat_accept) begin
`ifdef ADDEND_STREAM_PACKER_LAST_EN
                        // An early end clears every slot above the last beat.
                        if (addend_last_in) begin
                            for (int i = 0; i < NUMBER_OF_ADDENDS; i++) begin
                                if (i > int'(count)) addends_out[i] <= '0;
                            end
                        end
`endif
                        addends_out[count] <= addend_in;
                        if (end_of_txn) begin
                            count    <= '0;
                            wait_cnt <= WAIT_W'(ADDER_LATENCY);
                            state    <= WAIT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Vector stays put until the chain has had ADDER_LATENCY edges.
                    if (wait_cnt == '0) begin
                        sum_out       <= sum_in;
                        sum_valid_out <= 1'b1;
                        state         <= RESULT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESULT: begin
                    if (sum_ready_in) begin
                        sum_valid_out <= 1'b0;
                        state         <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_addend_stream_packer.sv
// Directed bench for addend_stream_packer with a latency-6 adder chain model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_addend_stream_packer;

    localparam int W  = 16;
    localparam int N  = 64;
    localparam int SW = 16;
    localparam int L  = 6;

    logic                   clk;
    logic                   rst;
    logic [W-1:0]           addend_in;
    logic                   addend_valid_in;
    logic                   addend_last_in;
    logic                   addend_ready_out;
    logic [N-1:0][W-1:0]    addends_out;
    logic [SW-1:0]          sum_in;
    logic [SW-1:0]          sum_out;
    logic                   sum_valid_out;
    logic                   sum_ready_in;
    logic                   busy_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [SW-1:0] exp_q[$];

    addend_stream_packer #(
        .ADDEND_WIDTH(W), .NUMBER_OF_ADDENDS(N),
        .FINAL_SUM_WIDTH(SW), .ADDER_LATENCY(L)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .addend_in(addend_in), .addend_valid_in(addend_valid_in),
        .addend_last_in(addend_last_in), .addend_ready_out(addend_ready_out),
        .addends_out(addends_out), .sum_in(sum_in),
        .sum_out(sum_out), .sum_valid_out(sum_valid_out),
        .sum_ready_in(sum_ready_in), .busy_out(busy_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // adder chain model: sum of the vector, delayed by L register stages
    function automatic logic [SW-1:0] vec_sum(input logic [N-1:0][W-1:0] v);
        logic [SW-1:0] s = '0;
        for (int i = 0; i < N; i++) s = s + SW'(v[i]);
        return s;
    endfunction

    logic [SW-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= vec_sum(addends_out);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign sum_in = pipe[L-1];

    typedef struct {
        logic [W-1:0]  base;
        bit            ramp;
        bit            gaps;
        logic [SW-1:0] exp_sum;
    } txn_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [N-1:0][W-1:0] exp);
        total_cnt++;
        if (addends_out === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, addends_out, exp);
    endtask

    // driver: called at a falling edge, returns at the falling edge after acceptance
    task automatic send_beat(input logic [W-1:0] v, input logic last);
        int guard = 0;
        addend_in       = v;
        addend_valid_in = 1'b1;
        addend_last_in  = last;
        while (!addend_ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("beat_ready_timeout", 32'(guard), 32'd0);
        @(negedge clk);
        addend_valid_in = 1'b0;
        addend_last_in  = 1'b0;
    endtask

    // after the last beat: count cycles to sum_valid_out, busy held the whole time
    task automatic finish_wait();
        int cyc = 0;
        int bad = 0;
        while (!sum_valid_out && cyc < 50) begin
            if (!busy_out || addend_ready_out) bad++;
            @(negedge clk);
            cyc++;
        end
        if (!busy_out || addend_ready_out) bad++;
        check("latency", 32'(cyc), 32'(L + 1));
        check("busy_in_wait", 32'(bad), 32'd0);
    endtask

    task automatic collect();
        logic [SW-1:0] exp;
        check("res_valid", 32'(sum_valid_out), 32'd1);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("sum_out", 32'(sum_out), 32'(exp));
        sum_ready_in = 1'b1;
        @(negedge clk);
        sum_ready_in = 1'b0;
        check("valid_drop", 32'(sum_valid_out), 32'd0);
        check("ready_back", 32'(addend_ready_out), 32'd1);
    endtask

    task automatic fill_and_wait(input txn_t t);
        logic [N-1:0][W-1:0] exp_vec;
        exp_q.push_back(t.exp_sum);
        for (int i = 0; i < N; i++) begin
            if (t.gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) @(negedge clk);
            end
            exp_vec[i] = t.ramp ? W'(t.base + W'(i)) : t.base;
            send_beat(exp_vec[i], 1'b0);
        end
        finish_wait();
        check_vec("slots", exp_vec);
    endtask

    txn_t vec [5];
    logic [N-1:0][W-1:0] v;
    logic [SW-1:0] held;
    int bp_bad;

    initial begin
        vec[0] = '{base: 16'h0002, ramp: 1'b0, gaps: 1'b0, exp_sum: 16'h0080};
        vec[1] = '{base: 16'h0400, ramp: 1'b0, gaps: 1'b0, exp_sum: 16'h0000};
        vec[2] = '{base: 16'h0003, ramp: 1'b0, gaps: 1'b0, exp_sum: 16'h00C0};
        vec[3] = '{base: 16'h0001, ramp: 1'b0, gaps: 1'b0, exp_sum: 16'h0040};
        vec[4] = '{base: 16'h0000, ramp: 1'b1, gaps: 1'b1, exp_sum: 16'h07E0};

        rst = 1'b1;
        addend_in = '0;
        addend_valid_in = 1'b0;
        addend_last_in = 1'b0;
        sum_ready_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        v = '0;
        check_vec("rst_slots", v);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_valid", 32'(sum_valid_out), 32'd0);
        check("rst_ready", 32'(addend_ready_out), 32'd1);
        check("rst_busy", 32'(busy_out), 32'd0);

        for (int k = 0; k < 5; k++) begin
            fill_and_wait(vec[k]);
            collect();
        end

        // backpressure: result held 20 cycles while beats are offered
        fill_and_wait('{base: 16'h0007, ramp: 1'b0, gaps: 1'b0, exp_sum: 16'h01C0});
        held = sum_out;
        bp_bad = 0;
        addend_in = 16'hFFFF;
        addend_valid_in = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (sum_out !== held || !sum_valid_out || addend_ready_out || !busy_out) bp_bad++;
        end
        check("bp_hold", 32'(bp_bad), 32'd0);
        addend_valid_in = 1'b0;
        collect();
        fill_and_wait('{base: 16'h0001, ramp: 1'b1, gaps: 1'b0, exp_sum: 16'h0820});
        check("slot0_after_bp", 32'(addends_out[0]), 32'd1);
        collect();

        // reset after beat 30 of a 64x2 transaction
        for (int i = 0; i < 31; i++) send_beat(16'h0002, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v = '0;
        check_vec("mid_rst_slots", v);
        check("mid_rst_sum", 32'(sum_out), 32'd0);
        check("mid_rst_valid", 32'(sum_valid_out), 32'd0);
        check("mid_rst_ready", 32'(addend_ready_out), 32'd1);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        fill_and_wait(vec[0]);
        collect();

        // early end: 10 beats of 5, last flagged on beat 9
`ifdef ADDEND_STREAM_PACKER_LAST_EN
        exp_q.push_back(16'h0032);
        for (int i = 0; i < 10; i++) send_beat(16'h0005, (i == 9));
        finish_wait();
        for (int i = 0; i < N; i++) v[i] = (i < 10) ? 16'h0005 : 16'h0000;
        check_vec("last_slots", v);
        collect();
`else
        for (int i = 0; i < 10; i++) send_beat(16'h0005, (i == 9));
        check("last_ign_ready", 32'(addend_ready_out), 32'd1);
        check("last_ign_busy", 32'(busy_out), 32'd0);
        check("last_ign_slot10", 32'(addends_out[10]), 32'h0002);
        for (int i = 10; i < N; i++) send_beat(16'h0005, 1'b0);
        exp_q.push_back(16'h0140);
        finish_wait();
        for (int i = 0; i < N; i++) v[i] = 16'h0005;
        check_vec("last_ign_slots", v);
        collect();
`endif

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
